// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: MIPS R-type funct codes, FSM state encoding, op-class helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_SLLV  = 6'd4;
    localparam logic [5:0] FN_SRLV  = 6'd6;
    localparam logic [5:0] FN_SRAV  = 6'd7;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] func);
        return (func == FN_MULT) || (func == FN_MULTU) ||
               (func == FN_DIV)  || (func == FN_DIVU);
    endfunction

    function automatic logic is_signed_md(input logic [5:0] func);
        return (func == FN_MULT) || (func == FN_DIV);
    endfunction

    function automatic logic is_div(input logic [5:0] func);
        return (func == FN_DIV) || (func == FN_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between register-read (master) and alu_seq (slave).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the result side.
// Signals: in_valid/in_ready/operand_a/operand_b/shamt/func (request),
//          out_valid/out_ready/result/result_hi/illegal (response).
interface alu_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   operand_b;
    logic [SHAMT_W-1:0] shamt;
    logic [5:0]         func;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   result_hi;
    logic               illegal;

    modport master (
        output in_valid, operand_a, operand_b, shamt, func, out_ready,
        input  in_ready, out_valid, result, result_hi, illegal
    );

    modport slave (
        input  in_valid, operand_a, operand_b, shamt, func, out_ready,
        output in_ready, out_valid, result, result_hi, illegal
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider on one shared WIDTH+1-bit adder.
// Latency: start edge, then WIDTH iteration edges; done is high in the following (fixup) cycle.
// Backpressure: none; en freezes all state, caller consumes lo/hi on the edge where done & en.
// Ports: clk, rst (sync, active-high), en, start, is_div, is_signed, a, b -> done, lo, hi.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic             run;
    logic [CNT_W-1:0] cnt;
    logic             div_op;
    logic             neg_q;     // quotient / product must be negated
    logic             neg_r;     // remainder takes the sign of the dividend
    logic             div_zero;
    logic [WIDTH-1:0] a_keep;    // raw dividend, returned as remainder on divide by zero
    logic [WIDTH-1:0] acc;       // product high half / partial remainder
    logic [WIDTH-1:0] q;         // multiplier shifting out, product low half / quotient shifting in
    logic [WIDTH-1:0] m;         // multiplicand / divisor magnitude

    // Input sign fixup happens as operands are captured so every iteration is unsigned.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Shared adder. Divide subtracts via {1,~m} + 1; carry-out means "fits", i.e. quotient bit 1.
    logic [WIDTH:0]   add_x, add_y;
    logic             add_ci;
    logic [WIDTH+1:0] add_sum;
    logic             add_co;

    always_comb begin
        add_x  = '0;
        add_y  = '0;
        add_ci = 1'b0;
        if (div_op) begin
            add_x  = {acc, q[WIDTH-1]};
            add_y  = {1'b1, ~m};
            add_ci = 1'b1;
        end else begin
            add_x  = {1'b0, acc};
            add_y  = q[0] ? {1'b0, m} : '0;
        end
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_ci};
    assign add_co  = add_sum[WIDTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            run      <= 1'b0;
            cnt      <= '0;
            div_op   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_keep   <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
        end else if (en) begin
            if (start) begin
                run      <= 1'b1;
                cnt      <= '0;
                div_op   <= is_div;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= is_div & (b == '0);
                a_keep   <= a;
                acc      <= '0;
                q        <= a_mag;
                m        <= b_mag;
            end else if (run) begin
                if (cnt == LAST) begin
                    run <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    if (div_op) begin
                        acc <= add_co ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], add_co};
                    end else begin
                        acc <= add_sum[WIDTH:1];
                        q   <= {add_sum[0], q[WIDTH-1:1]};
                    end
                end
            end
        end
    end

    assign done = run && (cnt == LAST);

    // Output sign fixup, consumed in the done cycle.
    logic [2*WIDTH-1:0] prod, prod_fix;
    assign prod     = {acc, q};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        lo = prod_fix[WIDTH-1:0];
        hi = prod_fix[2*WIDTH-1:WIDTH];
        if (div_op) begin
            if (div_zero) begin
                lo = '1;
                hi = a_keep;
            end else begin
                lo = neg_q ? -q : q;
                hi = neg_r ? -acc : acc;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered MIPS R-type ALU with iterative mult/div (macro ALU_SEQ_MULDIV_EN enables mult/div).
// Latency: 1 cycle for logic/shift/compare/illegal ops; WIDTH+1 enabled cycles for mult/div.
// Backpressure: result held with out_valid until out_ready; in_ready drops while busy or stalled.
// Ports: clk, rst (sync, active-high), clk_en (global hold), bus (alu_seq_if.slave:
//        in_valid/in_ready/operand_a/operand_b/shamt/func -> out_valid/out_ready/result/result_hi/illegal).
module alu_seq
    import alu_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               SHAMT_W        = $clog2(WIDTH),
    parameter logic [WIDTH-1:0] DEFAULT_RESULT = WIDTH'({(WIDTH+31)/32{32'hDEADBEEF}})
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clk_en,
    alu_seq_if.slave bus
);
    state_t           state, state_next;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             illegal_q;
    logic             in_ready;
    logic             accept, drain;
    logic             load_1c, load_md;
    state_t           issue_state;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0]   a, b;
    logic [SHAMT_W-1:0] sh_var;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ill;

    assign a      = bus.operand_a;
    assign b      = bus.operand_b;
    assign sh_var = a[SHAMT_W-1:0];

    always_comb begin
        alu_res = DEFAULT_RESULT;
        alu_ill = 1'b0;
        case (bus.func)
            FN_ADD, FN_ADDU: alu_res = a + b;
            FN_SUB, FN_SUBU: alu_res = a - b;
            FN_AND:          alu_res = a & b;
            FN_OR:           alu_res = a | b;
            FN_XOR:          alu_res = a ^ b;
            FN_NOR:          alu_res = ~(a | b);
            FN_SLT:          alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            FN_SLTU:         alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            FN_SLL:          alu_res = b << bus.shamt;
            FN_SRL:          alu_res = b >> bus.shamt;
            FN_SRA:          alu_res = $signed(b) >>> bus.shamt;
            FN_SLLV:         alu_res = b << sh_var;
            FN_SRLV:         alu_res = b >> sh_var;
            FN_SRAV:         alu_res = $signed(b) >>> sh_var;
            default:         alu_ill = 1'b1;
        endcase
    end

    // ---------------- handshake ----------------
`ifdef ALU_SEQ_MULDIV_EN
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
`else
    assign in_ready = (state == S_IDLE) || bus.out_ready;
`endif
    assign accept = bus.in_valid && in_ready && clk_en;
    assign drain  = (state == S_DONE) && bus.out_ready && clk_en;

    // ---------------- iterative mult/div ----------------
`ifdef ALU_SEQ_MULDIV_EN
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .en        (clk_en),
        .start     (accept && is_muldiv(bus.func)),
        .is_div    (is_div(bus.func)),
        .is_signed (is_signed_md(bus.func)),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .lo        (md_lo),
        .hi        (md_hi)
    );

    assign issue_state = is_muldiv(bus.func) ? S_BUSY : S_DONE;
`else
    assign issue_state = S_DONE;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_1c    = 1'b0;
        load_md    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = issue_state;
                    load_1c    = (issue_state == S_DONE);
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_BUSY: begin
                if (clk_en && md_done) begin
                    state_next = S_DONE;
                    load_md    = 1'b1;
                end
            end
`endif
            S_DONE: begin
                // Draining and issuing in the same cycle keeps single-cycle ops back-to-back.
                if (drain) begin
                    state_next = accept ? issue_state : S_IDLE;
                    load_1c    = accept && (issue_state == S_DONE);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            result_hi_q <= '0;
            illegal_q   <= 1'b0;
        end else if (clk_en) begin
            if (load_1c) begin
                result_q    <= alu_res;
                result_hi_q <= '0;
                illegal_q   <= alu_ill;
            end
`ifdef ALU_SEQ_MULDIV_EN
            else if (load_md) begin
                result_q    <= md_lo;
                result_hi_q <= md_hi;
                illegal_q   <= 1'b0;
            end
`endif
        end
    end

`ifndef ALU_SEQ_MULDIV_EN
    logic unused_md;
    assign unused_md = load_md;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        bus.func      = fn;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.shamt     = sh;
    endtask

    // One request issued while the previous result drains in the same cycle.
    task automatic b2b(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        drive(fn, a, b, sh);
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        step();
        chk({tag, ".out_valid"}, bus.out_valid, 1);
        chk({tag, ".result"}, bus.result, exp);
        chk({tag, ".illegal"}, bus.illegal, 0);
        chk({tag, ".result_hi"}, bus.result_hi, 0);
    endtask

`ifdef ALU_SEQ_MULDIV_EN
    task automatic md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                      input int stall);
        int cyc;
        drive(fn, a, b, 5'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        cyc = 0;
        chk({tag, ".in_ready_busy"}, bus.in_ready, 0);
        if (stall > 0) begin
            repeat (3) step();
            clk_en = 1'b0;
            repeat (stall) step();
            clk_en = 1'b1;
            cyc = 3 + stall;
        end
        while (!bus.out_valid && cyc < 200) begin
            step();
            cyc++;
        end
        chk({tag, ".latency"}, cyc, 33 + stall);
        chk({tag, ".lo"}, bus.result, exp_lo);
        chk({tag, ".hi"}, bus.result_hi, exp_hi);
        chk({tag, ".illegal"}, bus.illegal, 0);
        step();
        chk({tag, ".drained"}, bus.out_valid, 0);
    endtask
`endif

    initial begin
        rst           = 1'b1;
        clk_en        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(6'd0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.result", bus.result, 0);
        chk("rst.result_hi", bus.result_hi, 0);
        chk("rst.illegal", bus.illegal, 0);
        chk("rst.in_ready", bus.in_ready, 1);
        rst = 1'b0;
        step();

        // Basic add with wrap.
        b2b("add_wrap", 6'd32, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
        bus.in_valid = 1'b0;
        step();
        chk("add_wrap.drained", bus.out_valid, 0);

        // Back-to-back single-cycle ops.
        b2b("sub",      6'd34, 32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE);
        b2b("slt_t",    6'd42, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1);
        b2b("sra",      6'd3,  32'd0,         32'h8000_0000, 5'd4,  32'hF800_0000);
        b2b("addu_ovf", 6'd33, 32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000);
        b2b("add",      6'd32, 32'h1234_5678, 32'h1111_1111, 5'd0,  32'h2345_6789);
        b2b("subu",     6'd35, 32'd0,         32'd1,         5'd0,  32'hFFFF_FFFF);
        b2b("and",      6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000);
        b2b("or",       6'd37, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0,  32'hFFFF_F0F0);
        b2b("xor",      6'd38, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F);
        b2b("nor",      6'd39, 32'hF0F0_F0F0, 32'h0000_FFFF, 5'd0,  32'h0F0F_0000);
        b2b("slt_f",    6'd42, 32'd1,         32'hFFFF_FFFF, 5'd0,  32'd0);
        b2b("sltu_t",   6'd43, 32'd1,         32'hFFFF_FFFF, 5'd0,  32'd1);
        b2b("sltu_f",   6'd43, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0);
        b2b("sll",      6'd0,  32'd0,         32'd1,         5'd31, 32'h8000_0000);
        b2b("srl",      6'd2,  32'd0,         32'h8000_0000, 5'd4,  32'h0800_0000);
        b2b("sllv",     6'd4,  32'h24,        32'd1,         5'd0,  32'h10);
        b2b("srlv",     6'd6,  32'h28,        32'hFF00_0000, 5'd0,  32'h00FF_0000);
        b2b("srav",     6'd7,  32'h3F,        32'h8000_0000, 5'd0,  32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        step();
        chk("b2b.drained", bus.out_valid, 0);

        // Backpressure: result held, no new accept, single transfer on release.
        bus.out_ready = 1'b0;
        drive(6'd36, 32'hFFFF_0000, 32'h0FF0_0FF0, 5'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp.out_valid", bus.out_valid, 1);
            chk("bp.result", bus.result, 32'h0FF0_0000);
            chk("bp.in_ready", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp.released", bus.out_valid, 0);
        step();
        chk("bp.no_dup", bus.out_valid, 0);

        // clk_en low blocks both accept and drain.
        drive(6'd32, 32'd2, 32'd3, 5'd0);
        bus.in_valid = 1'b1;
        clk_en       = 1'b0;
        step();
        chk("en.no_accept", bus.out_valid, 0);
        clk_en = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("en.accept", bus.out_valid, 1);
        chk("en.result", bus.result, 32'd5);
        clk_en = 1'b0;
        step();
        chk("en.no_drain", bus.out_valid, 1);
        clk_en = 1'b1;
        step();
        chk("en.drain", bus.out_valid, 0);

        // Illegal func.
        drive(6'd63, 32'd1, 32'd2, 5'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("ill63.out_valid", bus.out_valid, 1);
        chk("ill63.result", bus.result, 32'hDEAD_BEEF);
        chk("ill63.result_hi", bus.result_hi, 0);
        chk("ill63.illegal", bus.illegal, 1);
        step();

        // Reset while holding a result clears it.
        bus.out_ready = 1'b0;
        drive(6'd37, 32'h1, 32'h2, 5'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("rst_done.held", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst_done.out_valid", bus.out_valid, 0);
        chk("rst_done.result", bus.result, 0);
        chk("rst_done.in_ready", bus.in_ready, 1);

`ifdef ALU_SEQ_MULDIV_EN
        md("mult",      6'd24, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 0);
        md("multu",     6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        md("divu_0",    6'd27, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100,       0);
        md("div_min",   6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         0);
        md("div_m7_2",  6'd26, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        md("div_7_m2",  6'd26, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         0);
        md("divu",      6'd27, 32'd100,       32'd7,         32'd14,        32'd2,         0);
        md("div_0",     6'd26, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
        md("mult_stall",6'd24, 32'd6,         32'd7,         32'd42,        32'd0,         5);

        // Abort an in-flight multiply.
        drive(6'd24, 32'd3, 32'd5, 5'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.out_valid", bus.out_valid, 0);
        chk("abort.in_ready", bus.in_ready, 1);
        repeat (40) step();
        chk("abort.discarded", bus.out_valid, 0);
`else
        drive(6'd24, 32'hFFFF_FFFD, 32'd7, 5'd0);
        bus.in_valid = 1'b1;
        step();
        chk("ill24.out_valid", bus.out_valid, 1);
        chk("ill24.result", bus.result, 32'hDEAD_BEEF);
        chk("ill24.result_hi", bus.result_hi, 0);
        chk("ill24.illegal", bus.illegal, 1);
        drive(6'd27, 32'd100, 32'd7, 5'd0);
        chk("ill27.in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("ill27.result", bus.result, 32'hDEAD_BEEF);
        chk("ill27.illegal", bus.illegal, 1);
        step();
        chk("ill27.drained", bus.out_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU in the llama core.
- Registered single-cycle logic, shift and compare ops, plus iterative multiply/divide producing hi/lo results.
- Sits between the decode/register-read stage and writeback.
- Valid/ready handshakes on both sides, so the pipeline stalls on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two and at least 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width.
- DEFAULT_RESULT, {WIDTH/32{32'hDEADBEEF}} truncated to WIDTH, result driven for illegal func.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global enable; when 0, all state, including the iteration counter, holds.
- in_valid  in  1  operands/func valid.
- in_ready  out  1  block can accept a request this cycle.
- operand_a  in  WIDTH  first operand (rs).
- operand_b  in  WIDTH  second operand (rt).
- shamt  in  SHAMT_W  immediate shift amount for sll/srl/sra.
- func  in  6  MIPS R-type funct code.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  low result (quotient or product low half).
- result_hi  out  WIDTH  remainder or product high half; 0 for non-muldiv ops.
- illegal  out  1  func was unsupported; qualified by out_valid.

Behaviour:
- Reset (rst=1 at an edge, regardless of clk_en):
  - state IDLE; out_valid=0, result=0, result_hi=0, illegal=0.
  - Any in-flight mult/div is aborted and discarded.
- Handshake:
  - A request transfers when in_valid & in_ready & clk_en.
  - A result transfers when out_valid & out_ready & clk_en.
  - out_valid stays high and outputs stay stable until the result is accepted.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). The out_ready term allows back-to-back issue with a same-cycle drain.
- States:
  - IDLE: on accept of a 1-cycle op, go to DONE. On accept of a muldiv op, go to BUSY.
  - BUSY: counter runs 0..WIDTH; at count WIDTH, load outputs and go to DONE.
  - DONE: on drain without a new accept, go to IDLE. On drain with a new accept, follow the IDLE rules.
- Latency:
  - 1-cycle ops: out_valid in the cycle after accept.
  - mult/multu/div/divu: out_valid exactly WIDTH+1 enabled cycles after accept (1 sign-fixup cycle plus WIDTH iterations).
- Ops and func codes (all modulo 2^WIDTH):
  - add 32, addu 33: a+b.
  - sub 34, subu 35: a-b.
  - and 36, or 37, xor 38.
  - nor 39: ~(a|b).
  - slt 42: signed a<b, gives 1 or 0. sltu 43: unsigned a<b, gives 1 or 0.
  - sll 0, srl 2, sra 3: shift b by shamt.
  - sllv 4, srlv 6, srav 7: shift b by a[SHAMT_W-1:0].
  - mult 24, multu 25: {result_hi,result} = a*b, 2*WIDTH bits, signed or unsigned respectively.
  - div 26, divu 27: result = a/b truncated toward zero, result_hi = remainder with the sign of a.
- Boundary rules:
  - Divide by zero: result = all ones, result_hi = a.
  - Signed MIN / -1: result = MIN, result_hi = 0.
  - Overflow on add/sub wraps silently.
  - Any other func: result = DEFAULT_RESULT, result_hi = 0, illegal = 1, 1-cycle latency.
- clk_en=0 during BUSY stretches latency by the number of disabled cycles. rst still takes effect.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: mult/multu/div/divu are implemented as above.
- Undefined:
  - The iterative datapath and BUSY state are removed.
  - Codes 24-27 are treated as illegal (DEFAULT_RESULT, illegal=1, 1-cycle latency).
  - in_ready = (state==IDLE) | out_ready.

Decomposition:
- Package alu_pkg holds:
  - localparam funct codes (FN_ADD ... FN_DIVU).
  - State encoding: IDLE, BUSY, DONE.
  - A helper function is_muldiv(func).
- Sub-module alu_muldiv_iter:
  - Radix-2 shift-add multiplier and restoring divider sharing one WIDTH+1-bit adder.
  - start/done interface, sign fixup internal.
  - Instantiated only under ALU_SEQ_MULDIV_EN.

Test Plan:
- Reset and basic add: with rst, out_valid=0 and result=0. Then add a=0xFFFFFFFF, b=1 -> next cycle out_valid=1, result=0, illegal=0.
- Back-to-back 1-cycle ops with out_ready=1: issue sub 5-7, slt -1<1, sra 0x80000000 shamt 4 on consecutive cycles.
  - Expect results 0xFFFFFFFE, 1, 0xF8000000 on consecutive cycles.
  - in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 for 3 cycles after an and -> result stable, in_ready=0. Release -> one transfer only, no duplicate.
- Multiply: mult a=-3, b=7 -> out_valid exactly 33 cycles after accept, {result_hi,result}=0xFFFFFFFF_FFFFFFEB. Meanwhile in_ready=0.
- Divide corners:
  - divu 100/0 -> result=0xFFFFFFFF, result_hi=100.
  - div 0x80000000/-1 -> result=0x80000000, result_hi=0.
  - div -7/2 -> result=-3, result_hi=-1.
- Mid-op reset and illegal func:
  - Assert rst at BUSY cycle 10 -> next cycle state IDLE, out_valid=0, in_ready=1.
  - func=63 -> result=0xDEADBEEF, illegal=1.
  - With the macro off, func=24 -> result=0xDEADBEEF, illegal=1.
